idex_ctrl_reg: RTL

IDEX_CTRL_REG -- requirements
Module: idex_ctrl_reg

---
 rtl/idex_ctrl_reg.sv | 103 ++++++++++
 1 files changed

// File: rtl/idex_ctrl_reg.sv
// ID/EX control pipeline register with the architectural NZCV flags register.
// Optional macro IDEX_PERF_CNT_EN adds saturating bubble/branch counters.
module idex_ctrl_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] CondD,
    input  logic [1:0] FlagWriteD,
    input  logic       BranchD,
    input  logic       RegWriteD,
    input  logic       MemWriteD,
    input  logic       PCSrcD,
    input  logic       NoWriteD,
    input  logic       ValidD,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       BranchTakenE,
    input  logic [3:0] NextFlagsE,
    output logic [3:0] CondE,
    output logic [1:0] FlagWriteE,
    output logic       BranchE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       PCSrcE,
    output logic       NoWriteE,
    output logic       ValidE,
    output logic [3:0] FlagsE
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [15:0] BubbleCnt,
    output logic [15:0] BranchCnt
`endif
);

    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flagwrite;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
        logic       pcsrc;
        logic       nowrite;
        logic       valid;
    } ctrl_t;

    // Bubble carries the AL condition so it is a harmless always-executed no-op.
    localparam ctrl_t BUBBLE = '{cond: 4'b1110, flagwrite: 2'b00, branch: 1'b0, regwrite: 1'b0,
                                 memwrite: 1'b0, pcsrc: 1'b0, nowrite: 1'b0, valid: 1'b0};

    ctrl_t ctrl_d, ctrl_q, ctrl_nxt;
    logic  bubble;

    assign bubble = FlushE | BranchTakenE;

    always_comb begin
        ctrl_d.cond      = CondD;
        ctrl_d.flagwrite = ValidD ? FlagWriteD : 2'b00;
        ctrl_d.branch    = ValidD & BranchD;
        ctrl_d.regwrite  = ValidD & RegWriteD;
        ctrl_d.memwrite  = ValidD & MemWriteD;
        ctrl_d.pcsrc     = ValidD & PCSrcD;
        ctrl_d.nowrite   = ValidD & NoWriteD;
        ctrl_d.valid     = ValidD;
    end

    always_comb begin
        ctrl_nxt = ctrl_d;
        if (bubble)      ctrl_nxt = BUBBLE;
        else if (StallE) ctrl_nxt = ctrl_q;
    end

    always_ff @(posedge clk) begin
        if (reset) ctrl_q <= BUBBLE;
        else       ctrl_q <= ctrl_nxt;
    end

    // Flags retire with the instruction leaving Execute; a stalled one has not left yet.
    always_ff @(posedge clk) begin
        if (reset)                        FlagsE <= 4'b0000;
        else if (ctrl_q.valid && !StallE) FlagsE <= NextFlagsE;
    end

    assign CondE      = ctrl_q.cond;
    assign FlagWriteE = ctrl_q.flagwrite;
    assign BranchE    = ctrl_q.branch;
    assign RegWriteE  = ctrl_q.regwrite;
    assign MemWriteE  = ctrl_q.memwrite;
    assign PCSrcE     = ctrl_q.pcsrc;
    assign NoWriteE   = ctrl_q.nowrite;
    assign ValidE     = ctrl_q.valid;

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            BubbleCnt <= 16'h0000;
            BranchCnt <= 16'h0000;
        end else begin
            if (bubble && BubbleCnt != 16'hFFFF)                         BubbleCnt <= BubbleCnt + 16'd1;
            if (BranchTakenE && ctrl_q.valid && BranchCnt != 16'hFFFF) BranchCnt <= BranchCnt + 16'd1;
        end
    end
`endif

endmodule
